bcd_step_decoder: RTL and testbench

Monitor/decoder on the consumer side of the 4-bit reversible decade counter. It samples the counter value every clock and reconstructs the events that produced it: single-step pulses with direction, decade carry/borrow, and reloads to zero. It also keeps a saturating signed net step count and flags impossible transitions. It sits beside the counter in the board-level design and feeds the display/diagnostic logic.

---
 rtl/counter_pkg.sv | 11 +
 rtl/bcd_step_classify.sv | 33 +++
 rtl/bcd_step_decoder.sv | 123 ++++++++++++
 tb/tb_bcd_step_decoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared decade-counter constants plus decoder state and event codes
package counter_pkg;

    localparam int DEF_MOD = 10;
    localparam int DEF_W   = 4;

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    typedef enum logic [2:0] {EV_NONE, EV_UP, EV_DOWN, EV_RELOAD, EV_ILLEGAL} event_t;

endpackage

// File: rtl/bcd_step_classify.sv
// bcd_step_classify: classifies a counter transition prev -> cnt into an event code and wrap flag
module bcd_step_classify
    import counter_pkg::*;
#(
    parameter int MOD = DEF_MOD,
    parameter int W   = DEF_W
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] cnt,
    output event_t       ev,
    output logic         wrap
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    logic         legal;
    logic [W-1:0] up_v;
    logic [W-1:0] dn_v;

    // adjacency is tested before the reload-to-zero case so 1->0 and 9->0 stay steps
    always_comb begin
        legal = {1'b0, cnt} < (W + 1)'(MOD);
        up_v  = prev == TOP ? '0 : prev + 1'b1;
        dn_v  = prev == '0 ? TOP : prev - 1'b1;
        ev    = !legal       ? EV_ILLEGAL :
                cnt == prev  ? EV_NONE    :
                cnt == up_v  ? EV_UP      :
                cnt == dn_v  ? EV_DOWN    :
                cnt == '0    ? EV_RELOAD  : EV_ILLEGAL;
        wrap  = (ev == EV_UP && prev == TOP) || (ev == EV_DOWN && prev == '0);
    end

endmodule

// File: rtl/bcd_step_decoder.sv
// bcd_step_decoder: reconstructs step/carry/borrow/reload events from a sampled decade counter
module bcd_step_decoder
    import counter_pkg::*;
#(
    parameter int MOD   = DEF_MOD,
    parameter int W     = DEF_W,
    parameter int NET_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            cnt,
    input  logic                    clr,
    output logic                    step,
    output logic                    dir,
    output logic                    carry,
    output logic                    borrow,
    output logic                    reload,
    output logic                    err,
    output logic signed [NET_W-1:0] net,
    output logic                    synced
);

    localparam logic signed [NET_W-1:0] NMAX = {1'b0, {(NET_W - 1){1'b1}}};
    localparam logic signed [NET_W-1:0] NMIN = {1'b1, {(NET_W - 1){1'b0}}};

    state_t                  state, state_n;
    event_t                  ev;
    logic                    wrap;
    logic                    legal;
    logic [W-1:0]            prev, prev_n;
    logic                    step_n, dir_n, carry_n, borrow_n, reload_n, err_n;
    logic signed [NET_W-1:0] net_n;

    bcd_step_classify #(.MOD(MOD), .W(W)) u_classify (
        .prev (prev),
        .cnt  (cnt),
        .ev   (ev),
        .wrap (wrap)
    );

    assign legal  = {1'b0, cnt} < (W + 1)'(MOD);
    assign synced = state == TRACK;

    // next state and next outputs; clr overrides classification, pulses default low
    always_comb begin
        state_n  = state;
        prev_n   = prev;
        dir_n    = dir;
        net_n    = net;
        err_n    = err;
        step_n   = 1'b0;
        carry_n  = 1'b0;
        borrow_n = 1'b0;
        reload_n = 1'b0;
        if (clr) begin
            state_n = SYNC;
            net_n   = '0;
            err_n   = 1'b0;
            dir_n   = 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    prev_n  = legal ? cnt : prev;
                    state_n = legal ? TRACK : SYNC;
                end
                TRACK: begin
                    case (ev)
                        EV_UP: begin
                            step_n  = 1'b1;
                            dir_n   = 1'b0;
                            carry_n = wrap;
                            net_n   = net == NMAX ? net : net + NET_W'(1);
                            prev_n  = cnt;
                        end
                        EV_DOWN: begin
                            step_n   = 1'b1;
                            dir_n    = 1'b1;
                            borrow_n = wrap;
                            net_n    = net == NMIN ? net : net - NET_W'(1);
                            prev_n   = cnt;
                        end
                        EV_RELOAD: begin
                            reload_n = 1'b1;
                            prev_n   = cnt;
                        end
                        EV_ILLEGAL: begin
                            err_n   = 1'b1;
                            state_n = FAULT;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // state, PREV, accumulator and output registers; rst beats clr
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SYNC;
            prev   <= '0;
            step   <= 1'b0;
            dir    <= 1'b0;
            carry  <= 1'b0;
            borrow <= 1'b0;
            reload <= 1'b0;
            err    <= 1'b0;
            net    <= '0;
        end else begin
            state  <= state_n;
            prev   <= prev_n;
            step   <= step_n;
            dir    <= dir_n;
            carry  <= carry_n;
            borrow <= borrow_n;
            reload <= reload_n;
            err    <= err_n;
            net    <= net_n;
        end
    end

endmodule

// File: tb/tb_bcd_step_decoder.sv
// tb_bcd_step_decoder: directed scoreboard bench for the decade-counter step decoder
module tb_bcd_step_decoder;

    localparam int MOD   = 10;
    localparam int W     = 4;
    localparam int NET_W = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clr = 1'b0;
    logic [W-1:0]            cnt = '0;
    logic                    step, dir, carry, borrow, reload, err, synced;
    logic signed [NET_W-1:0] net;

    bcd_step_decoder #(.MOD(MOD), .W(W), .NET_W(NET_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .cnt    (cnt),
        .clr    (clr),
        .step   (step),
        .dir    (dir),
        .carry  (carry),
        .borrow (borrow),
        .reload (reload),
        .err    (err),
        .net    (net),
        .synced (synced)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int steps_seen, carries_seen, borrows_seen, reloads_seen;

    // reference model state: 0 = sync, 1 = track, 2 = fault
    int m_state = 0;
    int m_prev  = 0;
    int m_net   = 0;
    bit m_dir, m_err, m_step, m_carry, m_borrow, m_reload;

    logic [14:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model(input int c, input bit cl, input bit r);
        m_step = 0; m_carry = 0; m_borrow = 0; m_reload = 0;
        if (r) begin
            m_state = 0; m_prev = 0; m_net = 0; m_dir = 0; m_err = 0;
        end else if (cl) begin
            m_state = 0; m_net = 0; m_dir = 0; m_err = 0;
        end else if (m_state == 0) begin
            if (c < MOD) begin
                m_prev = c; m_state = 1;
            end
        end else if (m_state == 1) begin
            if (c >= MOD) begin
                m_err = 1; m_state = 2;
            end else if (c == m_prev) begin
            end else if (c == (m_prev + 1) % MOD) begin
                m_step = 1; m_dir = 0; m_carry = (m_prev == MOD - 1);
                m_net = (m_net >= 127) ? 127 : m_net + 1;
                m_prev = c;
            end else if (c == (m_prev + MOD - 1) % MOD) begin
                m_step = 1; m_dir = 1; m_borrow = (m_prev == 0);
                m_net = (m_net <= -128) ? -128 : m_net - 1;
                m_prev = c;
            end else if (c == 0) begin
                m_reload = 1; m_prev = 0;
            end else begin
                m_err = 1; m_state = 2;
            end
        end
    endtask

    task automatic tick(input int c, input bit cl, input bit r, input string tag);
        logic [14:0] e, o;
        cnt = W'(c); clr = cl; rst = r;
        model(c, cl, r);
        exp_q.push_back({m_step, m_dir, m_carry, m_borrow, m_reload, m_err, (m_state == 1) ? 1'b1 : 1'b0, NET_W'(m_net)});
        @(posedge clk);
        #1;
        o = {step, dir, carry, borrow, reload, err, synced, net};
        e = exp_q.pop_front();
        check(tag, 32'(o), 32'(e));
        if (step) steps_seen++;
        if (carry) carries_seen++;
        if (borrow) borrows_seen++;
        if (reload) reloads_seen++;
    endtask

    task automatic clear_counts();
        steps_seen = 0; carries_seen = 0; borrows_seen = 0; reloads_seen = 0;
    endtask

    initial begin
        int v;
        clear_counts();
        tick(0, 0, 1, "reset0");
        tick(0, 0, 1, "reset1");
        check("reset_outputs", 32'({step, dir, carry, borrow, reload, err, synced, net}), 32'd0);
        tick(0, 0, 0, "sync0");
        tick(0, 0, 0, "hold0");
        clear_counts();
        for (int i = 1; i <= 10; i++) begin
            tick(i % MOD, 0, 0, "count_up");
            tick(i % MOD, 0, 0, "count_up_hold");
        end
        check("up_steps", steps_seen, 10);
        check("up_carries", carries_seen, 1);
        check("up_net", 32'(net), 32'(8'sd10));
        clear_counts();
        tick(9, 0, 0, "down_borrow");
        tick(9, 0, 0, "down_hold");
        tick(8, 0, 0, "down_step");
        tick(8, 0, 0, "down_hold2");
        check("down_borrows", borrows_seen, 1);
        check("down_dir", 32'(dir), 32'd1);
        check("down_net", 32'(net), 32'(8'sd8));
        tick(7, 0, 0, "to7");
        tick(6, 0, 0, "to6");
        clear_counts();
        tick(0, 0, 0, "reload");
        tick(0, 0, 0, "reload_hold");
        check("reload_once", reloads_seen, 1);
        check("reload_nostep", steps_seen, 0);
        tick(1, 0, 0, "after_reload_up");
        tick(2, 0, 0, "to2");
        tick(3, 0, 0, "to3");
        tick(7, 0, 0, "jump_err");
        clear_counts();
        tick(8, 0, 0, "fault8");
        tick(9, 0, 0, "fault9");
        check("fault_nostep", steps_seen, 0);
        tick(9, 1, 0, "clr");
        tick(9, 0, 0, "resync");
        tick(12, 0, 1, "rst12");
        tick(12, 0, 0, "sync12a");
        tick(12, 0, 0, "sync12b");
        tick(4, 0, 0, "sync4");
        clear_counts();
        v = 4;
        for (int i = 0; i < 130; i++) begin
            v = (v + 1) % MOD;
            tick(v, 0, 0, "sat_up");
        end
        check("sat_steps", steps_seen, 130);
        check("sat_net", 32'(net), 32'(8'sd127));
        tick(v, 1, 1, "rst_clr");
        check("rst_clr_outputs", 32'({step, dir, carry, borrow, reload, err, synced, net}), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
